// File: rtl/alu_postprocess_if.sv
// ALU post-processing stage bus.
// Groups the producer handshake (in_valid/in_ready plus the raw ALU
// outputs), the consumer handshake (out_valid/out_ready plus the head
// entry) and the FIFO status/overflow sideband.
//   master : drives the ALU-side inputs, out_ready and ov_clear (testbench/system)
//   slave  : the post-processing block itself
interface alu_postprocess_if #(
  parameter int CNTW = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      Op;
  logic [3:0]      Sum;
  logic            Cout;
  logic [3:0]      LogicR;
  logic            AMsb;
  logic            BMsb;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      Result;
  logic [3:0]      Flags;
  logic [CNTW-1:0] count;
  logic            ov_sticky;
  logic            ov_clear;

  modport master (
    output in_valid, Op, Sum, Cout, LogicR, AMsb, BMsb, out_ready, ov_clear,
    input  in_ready, out_valid, Result, Flags, count, ov_sticky
  );

  modport slave (
    input  in_valid, Op, Sum, Cout, LogicR, AMsb, BMsb, out_ready, ov_clear,
    output in_ready, out_valid, Result, Flags, count, ov_sticky
  );
endinterface

// File: rtl/alu_postprocess.sv
// ALU output stage: selects the result (adder sum or logic-unit output),
// derives the {Z,N,C,V} flags and queues {result, flags} in a DEPTH-entry
// FIFO with valid/ready on both sides and a sticky overflow indicator.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (control state only; the entry
//           storage is never reset, outputs are masked while empty)
//   bus   : alu_postprocess_if.slave -- producer side (in_valid, in_ready,
//           Op, Sum, Cout, LogicR, AMsb, BMsb), consumer side (out_valid,
//           out_ready, Result, Flags) and status (count, ov_sticky, ov_clear)
module alu_postprocess #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_postprocess_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  // Builds the stored entry {R, Z, N, C, V}. Carry and overflow only have
  // meaning for the adder path, so they are masked for logic ops.
  function automatic logic [7:0] make_entry(
    input logic [2:0] op,
    input logic [3:0] sum,
    input logic       cout,
    input logic [3:0] logicr,
    input logic       amsb,
    input logic       bmsb
  );
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    r = op[2] ? logicr : sum;
    z = (r == 4'd0);
    n = r[3];
    c = ~op[2] & cout;
    v = ~op[2] & (amsb == bmsb) & (sum[3] != amsb);
    return {r, z, n, c, v};
  endfunction

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt;
  logic            ov_q;

  logic [7:0]      entry_p0;
  logic            push_p0;
  logic            pop_p0;
  logic            full;
  logic            empty;

  // Stage 0: combinational entry formation and handshake decode
  assign entry_p0 = make_entry(bus.Op, bus.Sum, bus.Cout, bus.LogicR,
                               bus.AMsb, bus.BMsb);
  assign full     = (cnt == FULL);
  assign empty    = (cnt == '0);
  // No pass-through at full: in_ready depends on occupancy alone.
  assign push_p0  = bus.in_valid & ~full;
  assign pop_p0   = bus.out_ready & ~empty;

  // Stage 1: FIFO storage and control registers
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem[wr_ptr] <= entry_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ov_q   <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push_p0) wr_ptr <= wr_ptr + PW'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_p0, pop_p0})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
      // A new overflow outranks a clear request in the same cycle.
      if (push_p0 && entry_p0[0]) begin
        ov_q <= 1'b1;
      end else if (bus.ov_clear) begin
        ov_q <= 1'b0;
      end
    end
  end

  // Stage 2: head-of-queue outputs, zeroed while empty
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.Result    = empty ? 4'd0 : mem[rd_ptr][7:4];
  assign bus.Flags     = empty ? 4'd0 : mem[rd_ptr][3:0];
  assign bus.count     = cnt;
  assign bus.ov_sticky = ov_q;

endmodule
